// File: rtl/sha256_msg_schedule.sv
// SHA-256 message schedule: loads one padded 512-bit block and streams the
// round inputs (W_t, K_t) one per handshake, expanding W with a 16-word
// sliding window so only 16 words of storage are needed.
module sha256_msg_schedule #(
  parameter int ROUNDS = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         blk_valid,
  output logic         blk_ready,
  input  logic [511:0] blk_data,
  output logic         w_valid,
  input  logic         w_ready,
  output logic [31:0]  w_out,
  output logic [31:0]  k_out,
  output logic [5:0]   t_idx,
  output logic         w_last
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;
  localparam logic [5:0] LAST_T  = 6'(ROUNDS - 1);

  logic [0:0]  state_r;
  logic [5:0]  t_r;
  logic [31:0] win_r [16];
  logic [31:0] next_w_s;
  logic        hs_s;

  // small sigma 0: rotr7 ^ rotr18 ^ shr3
  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
  endfunction

  // small sigma 1: rotr17 ^ rotr19 ^ shr10
  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0000000000, x[31:10]};
  endfunction

  // Round constant ROM (FIPS 180-4 K table)
  function automatic logic [31:0] k_rom(input logic [5:0] t);
    case (t)
      6'd0:  return 32'h428a2f98;  6'd1:  return 32'h71374491;
      6'd2:  return 32'hb5c0fbcf;  6'd3:  return 32'he9b5dba5;
      6'd4:  return 32'h3956c25b;  6'd5:  return 32'h59f111f1;
      6'd6:  return 32'h923f82a4;  6'd7:  return 32'hab1c5ed5;
      6'd8:  return 32'hd807aa98;  6'd9:  return 32'h12835b01;
      6'd10: return 32'h243185be;  6'd11: return 32'h550c7dc3;
      6'd12: return 32'h72be5d74;  6'd13: return 32'h80deb1fe;
      6'd14: return 32'h9bdc06a7;  6'd15: return 32'hc19bf174;
      6'd16: return 32'he49b69c1;  6'd17: return 32'hefbe4786;
      6'd18: return 32'h0fc19dc6;  6'd19: return 32'h240ca1cc;
      6'd20: return 32'h2de92c6f;  6'd21: return 32'h4a7484aa;
      6'd22: return 32'h5cb0a9dc;  6'd23: return 32'h76f988da;
      6'd24: return 32'h983e5152;  6'd25: return 32'ha831c66d;
      6'd26: return 32'hb00327c8;  6'd27: return 32'hbf597fc7;
      6'd28: return 32'hc6e00bf3;  6'd29: return 32'hd5a79147;
      6'd30: return 32'h06ca6351;  6'd31: return 32'h14292967;
      6'd32: return 32'h27b70a85;  6'd33: return 32'h2e1b2138;
      6'd34: return 32'h4d2c6dfc;  6'd35: return 32'h53380d13;
      6'd36: return 32'h650a7354;  6'd37: return 32'h766a0abb;
      6'd38: return 32'h81c2c92e;  6'd39: return 32'h92722c85;
      6'd40: return 32'ha2bfe8a1;  6'd41: return 32'ha81a664b;
      6'd42: return 32'hc24b8b70;  6'd43: return 32'hc76c51a3;
      6'd44: return 32'hd192e819;  6'd45: return 32'hd6990624;
      6'd46: return 32'hf40e3585;  6'd47: return 32'h106aa070;
      6'd48: return 32'h19a4c116;  6'd49: return 32'h1e376c08;
      6'd50: return 32'h2748774c;  6'd51: return 32'h34b0bcb5;
      6'd52: return 32'h391c0cb3;  6'd53: return 32'h4ed8aa4a;
      6'd54: return 32'h5b9cca4f;  6'd55: return 32'h682e6ff3;
      6'd56: return 32'h748f82ee;  6'd57: return 32'h78a5636f;
      6'd58: return 32'h84c87814;  6'd59: return 32'h8cc70208;
      6'd60: return 32'h90befffa;  6'd61: return 32'ha4506ceb;
      6'd62: return 32'hbef9a3f7;  6'd63: return 32'hc67178f2;
      default: return 32'h00000000;
    endcase
  endfunction

  // Next window word W_{t+16}; only committed on a handshake
  always_comb begin
    next_w_s = ssig1(win_r[14]) + win_r[9] + ssig0(win_r[1]) + win_r[0];
    if (state_r == ST_RUN) begin
      hs_s = w_ready;
    end else begin
      hs_s = 1'b0;
    end
  end

  // FSM, round counter and sliding window; reset wins over any handshake
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      t_r     <= 6'd0;
      for (int i = 0; i < 16; i++) begin
        win_r[i] <= 32'h00000000;
      end
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (blk_valid) begin
            for (int i = 0; i < 16; i++) begin
              win_r[i] <= blk_data[511 - 32*i -: 32];
            end
            t_r     <= 6'd0;
            state_r <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (hs_s) begin
            for (int i = 0; i < 15; i++) begin
              win_r[i] <= win_r[i+1];
            end
            win_r[15] <= next_w_s;
            if (t_r == LAST_T) begin
              t_r     <= 6'd0;
              state_r <= ST_IDLE;
            end else begin
              t_r <= t_r + 6'd1;
            end
          end
        end
        default: begin
          state_r <= ST_IDLE;
          t_r     <= 6'd0;
        end
      endcase
    end
  end

  // Outputs decode straight from registered state; no input-to-output path
  assign blk_ready = (state_r == ST_IDLE);
  assign w_valid   = (state_r == ST_RUN);
  assign w_out     = win_r[0];
  assign k_out     = k_rom(t_r);
  assign t_idx     = t_r;
  assign w_last    = (state_r == ST_RUN) && (t_r == LAST_T);

endmodule

// File: tb/tb_sha256_msg_schedule.sv
// Self-checking bench for sha256_msg_schedule: directed sequence with random
// blocks and random backpressure, checked against a full-array W/K model.
module tb_sha256_msg_schedule;

  localparam int R = 64;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         blk_valid = 1'b0;
  logic         blk_ready;
  logic [511:0] blk_data = '0;
  logic         w_valid;
  logic         w_ready = 1'b0;
  logic [31:0]  w_out;
  logic [31:0]  k_out;
  logic [5:0]   t_idx;
  logic         w_last;

  logic         blk_valid_b = 1'b0;
  logic         blk_ready_b;
  logic [511:0] blk_data_b = '0;
  logic         w_valid_b;
  logic         w_ready_b = 1'b0;
  logic [31:0]  w_out_b;
  logic [31:0]  k_out_b;
  logic [5:0]   t_idx_b;
  logic         w_last_b;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_w [64];
  logic [31:0] obs_w [64];
  logic [31:0] obs_k [64];
  int          hs_done;

  localparam logic [511:0] ABC = {32'h61626380, {14{32'h00000000}}, 32'h00000018};

  logic [31:0] kt [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  sha256_msg_schedule #(.ROUNDS(R)) dut (
    .clk(clk), .rst(rst), .blk_valid(blk_valid), .blk_ready(blk_ready),
    .blk_data(blk_data), .w_valid(w_valid), .w_ready(w_ready), .w_out(w_out),
    .k_out(k_out), .t_idx(t_idx), .w_last(w_last)
  );

  sha256_msg_schedule #(.ROUNDS(16)) dut16 (
    .clk(clk), .rst(rst), .blk_valid(blk_valid_b), .blk_ready(blk_ready_b),
    .blk_data(blk_data_b), .w_valid(w_valid_b), .w_ready(w_ready_b), .w_out(w_out_b),
    .k_out(k_out_b), .t_idx(t_idx_b), .w_last(w_last_b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Whole-schedule reference: all 64 words from the textbook recurrence
  task automatic build_model(input logic [511:0] blk);
    for (int i = 0; i < 16; i++) exp_w[i] = blk[511 - 32*i -: 32];
    for (int t = 16; t < 64; t++) begin
      exp_w[t] = (rotr(exp_w[t-2], 17) ^ rotr(exp_w[t-2], 19) ^ (exp_w[t-2] >> 10))
               + exp_w[t-7]
               + (rotr(exp_w[t-15], 7) ^ rotr(exp_w[t-15], 18) ^ (exp_w[t-15] >> 3))
               + exp_w[t-16];
    end
  endtask

  function automatic logic [511:0] rand_blk();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[511 - 32*i -: 32] = $urandom();
    return r;
  endfunction

  // Load a block from IDLE; returns at the negedge where W0 should be visible
  task automatic load_block(input logic [511:0] blk);
    @(negedge clk);
    chk("load_blk_ready", 64'(blk_ready), 64'd1);
    blk_valid = 1'b1;
    blk_data  = blk;
    @(negedge clk);
    blk_valid = 1'b0;
    blk_data  = rand_blk();
  endtask

  // Consume nwords words with w_ready high pct% of cycles, checking every cycle
  task automatic stream(input int pct, input int nwords);
    int  hs;
    int  cyc;
    logic rdy;
    hs = 0;
    cyc = 0;
    while (hs < nwords && cyc < 2000) begin
      chk("w_valid", 64'(w_valid), 64'd1);
      chk("blk_ready_run", 64'(blk_ready), 64'd0);
      chk("w_out", 64'(w_out), 64'(exp_w[hs]));
      chk("k_out", 64'(k_out), 64'(kt[hs]));
      chk("t_idx", 64'(t_idx), 64'(hs));
      chk("w_last", 64'(w_last), 64'(hs == R - 1));
      rdy = (pct >= 100) ? 1'b1 : ($urandom_range(99) < pct);
      w_ready = rdy;
      obs_w[hs] = w_out;
      obs_k[hs] = k_out;
      @(negedge clk);
      if (rdy) hs++;
      cyc++;
    end
    w_ready = 1'b0;
    hs_done = hs;
    chk("stream_budget", 64'(cyc < 2000), 64'd1);
  endtask

  task automatic end_of_block();
    chk("handshakes", 64'(hs_done), 64'(R));
    chk("idle_w_valid", 64'(w_valid), 64'd0);
    chk("idle_blk_ready", 64'(blk_ready), 64'd1);
  endtask

  initial begin
    logic [511:0] b1;
    logic [511:0] b2;

    // 1: reset held two cycles
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("rst_blk_ready", 64'(blk_ready), 64'd1);
    chk("rst_w_valid", 64'(w_valid), 64'd0);
    chk("rst_t_idx", 64'(t_idx), 64'd0);
    chk("rst_w_out", 64'(w_out), 64'd0);
    chk("rst_k_out", 64'(k_out), 64'(kt[0]));
    chk("rst_w_last", 64'(w_last), 64'd0);
    rst = 1'b0;

    // 2: "abc" block, full rate
    build_model(ABC);
    load_block(ABC);
    stream(100, R);
    end_of_block();
    chk("abc_t0", 64'(obs_w[0]), 64'h61626380);
    chk("abc_t15", 64'(obs_w[15]), 64'h00000018);
    chk("abc_t16", 64'(obs_w[16]), 64'h61626380);
    chk("abc_t17", 64'(obs_w[17]), 64'h000F0000);
    chk("abc_t18", 64'(obs_w[18]), 64'h7DA86405);
    chk("abc_k0", 64'(obs_k[0]), 64'h428A2F98);
    chk("abc_k63", 64'(obs_k[63]), 64'hC67178F2);

    // 3: same block under 50% backpressure, then a random block the same way
    load_block(ABC);
    stream(50, R);
    end_of_block();
    b1 = rand_blk();
    build_model(b1);
    load_block(b1);
    stream(50, R);
    end_of_block();

    // 4: next block offered throughout RUN; taken only once back in IDLE
    b1 = rand_blk();
    b2 = rand_blk();
    build_model(b1);
    load_block(b1);
    blk_valid = 1'b1;
    blk_data  = b2;
    stream(100, R);
    end_of_block();
    @(negedge clk);
    blk_valid = 1'b0;
    build_model(b2);
    chk("b2b_w_valid", 64'(w_valid), 64'd1);
    chk("b2b_w0", 64'(w_out), 64'(b2[511:480]));
    chk("b2b_t0", 64'(t_idx), 64'd0);
    stream(100, R);
    end_of_block();

    // 5: reset at t=20 with a handshake pending, then a fresh "abc" load
    b1 = rand_blk();
    build_model(b1);
    load_block(b1);
    stream(70, 20);
    chk("pre_rst_t", 64'(t_idx), 64'd20);
    rst = 1'b1;
    w_ready = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    w_ready = 1'b0;
    chk("midrst_w_valid", 64'(w_valid), 64'd0);
    chk("midrst_blk_ready", 64'(blk_ready), 64'd1);
    chk("midrst_t_idx", 64'(t_idx), 64'd0);
    chk("midrst_w_out", 64'(w_out), 64'd0);
    build_model(ABC);
    load_block(ABC);
    stream(100, R);
    end_of_block();

    // 6: ROUNDS=16 instance emits exactly the 16 block words
    b1 = rand_blk();
    @(negedge clk);
    chk("r16_blk_ready", 64'(blk_ready_b), 64'd1);
    blk_valid_b = 1'b1;
    blk_data_b  = b1;
    @(negedge clk);
    blk_valid_b = 1'b0;
    blk_data_b  = '0;
    w_ready_b   = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk("r16_w_valid", 64'(w_valid_b), 64'd1);
      chk("r16_w_out", 64'(w_out_b), 64'(b1[511 - 32*i -: 32]));
      chk("r16_k_out", 64'(k_out_b), 64'(kt[i]));
      chk("r16_t_idx", 64'(t_idx_b), 64'(i));
      chk("r16_w_last", 64'(w_last_b), 64'(i == 15));
      @(negedge clk);
    end
    w_ready_b = 1'b0;
    chk("r16_end_w_valid", 64'(w_valid_b), 64'd0);
    chk("r16_end_blk_ready", 64'(blk_ready_b), 64'd1);
    chk("r16_end_t_idx", 64'(t_idx_b), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
